// File: rtl/sm83_pkg.sv
// Shared SM83 datapath types: register byte, flag nibble, ALU opcodes and ALU result.
package sm83_pkg;

    typedef logic [7:0] r8_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    typedef enum logic [4:0] {
        OP_NOP,
        OP_ADD,
        OP_ADC,
        OP_SUB,
        OP_SBC,
        OP_AND,
        OP_XOR,
        OP_OR,
        OP_CP,
        OP_INC,
        OP_DEC,
        OP_RLC,
        OP_RRC,
        OP_RL,
        OP_RR,
        OP_SLA,
        OP_SRA,
        OP_SWAP,
        OP_SRL,
        OP_BIT,
        OP_RES,
        OP_SET
    } alu_op_t;

    typedef logic [7:0] alu_res_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of issue, register-file, memory and ALU signals around the ALU issue stage.
interface alu_issue_if;
    import sm83_pkg::*;

    logic         issue_valid;
    logic         issue_ready;
    alu_op_t      issue_op;
    logic [2:0]   issue_src;
    logic         issue_imm;
    logic [2:0]   issue_bit;
    logic [1:0]   issue_wb;
    logic [2:0]   rf_rd_sel;
    r8_t          rf_rd_data;
    r8_t          rf_a;
    flags_t       rf_f;
    logic         rf_wr_en;
    logic [2:0]   rf_wr_sel;
    r8_t          rf_wr_data;
    logic         f_wr_en;
    flags_t       f_wr_data;
    logic         mem_req;
    logic         mem_we;
    logic         mem_addr_sel;
    r8_t          mem_wdata;
    logic         mem_ack;
    r8_t          mem_rdata;
    r8_t          alu_op1;
    r8_t          alu_op2;
    alu_op_t      alu_op_o;
    flags_t       alu_in_flags;
    alu_res_t     alu_result;
    flags_t       alu_out_flags;
    logic         done;

    // The issue stage itself.
    modport master (
        input  issue_valid, issue_op, issue_src, issue_imm, issue_bit, issue_wb,
        input  rf_rd_data, rf_a, rf_f, mem_ack, mem_rdata, alu_result, alu_out_flags,
        output issue_ready, rf_rd_sel, rf_wr_en, rf_wr_sel, rf_wr_data, f_wr_en, f_wr_data,
        output mem_req, mem_we, mem_addr_sel, mem_wdata,
        output alu_op1, alu_op2, alu_op_o, alu_in_flags, done
    );

    // Decoder, register file, memory and ALU surrounding the stage.
    modport slave (
        output issue_valid, issue_op, issue_src, issue_imm, issue_bit, issue_wb,
        output rf_rd_data, rf_a, rf_f, mem_ack, mem_rdata, alu_result, alu_out_flags,
        input  issue_ready, rf_rd_sel, rf_wr_en, rf_wr_sel, rf_wr_data, f_wr_en, f_wr_data,
        input  mem_req, mem_we, mem_addr_sel, mem_wdata,
        input  alu_op1, alu_op2, alu_op_o, alu_in_flags, done
    );

endinterface

// File: rtl/alu_issue.sv
// Issue stage in front of the SM83 ALU: gathers the operand (register, (HL) or immediate),
// runs the ALU for one cycle and writes result/flags back to the register file or (HL).
module alu_issue
    import sm83_pkg::*;
(
    input logic         clk,
    input logic         rst,
    alu_issue_if.master bus_io
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StStore} state_e;

    state_e     state_q, state_d;
    alu_op_t    op_q;
    logic [2:0] src_q;
    logic [2:0] bit_q;
    logic       imm_q;
    logic [1:0] wb_q;
    r8_t        operand_q;
    r8_t        result_q;
    r8_t        op1_q;
    r8_t        op2_q;

    logic is_bitop;
    logic wb_store;
    logic wb_reg;
    r8_t  op1_exec;

    assign is_bitop = (op_q == OP_BIT) || (op_q == OP_RES) || (op_q == OP_SET);
    assign op1_exec = is_bitop ? {5'b0, bit_q} : bus_io.rf_a;
    // Writeback to "same location" only exists for register or (HL) sources, never immediates.
    assign wb_store = (op_q != OP_NOP) && (wb_q == 2'd2) && !imm_q && (src_q == 3'd6);
    assign wb_reg   = (op_q != OP_NOP) && (wb_q == 2'd2) && !imm_q && (src_q != 3'd6);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.issue_valid) begin
                    state_d = (bus_io.issue_imm || bus_io.issue_src == 3'd6) ? StFetch : StExec;
                end
            end
            StFetch: if (bus_io.mem_ack) state_d = StExec;
            StExec:  state_d = wb_store ? StStore : StIdle;
            StStore: if (bus_io.mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_NOP;
            src_q     <= 3'd0;
            bit_q     <= 3'd0;
            imm_q     <= 1'b0;
            wb_q      <= 2'd0;
            operand_q <= 8'h00;
            result_q  <= 8'h00;
            op1_q     <= 8'h00;
            op2_q     <= 8'h00;
        end else begin
            if (state_q == StIdle && bus_io.issue_valid) begin
                op_q      <= bus_io.issue_op;
                src_q     <= bus_io.issue_src;
                bit_q     <= bus_io.issue_bit;
                imm_q     <= bus_io.issue_imm;
                wb_q      <= bus_io.issue_wb;
                operand_q <= (bus_io.issue_src == 3'd7) ? bus_io.rf_a : bus_io.rf_rd_data;
            end
            if (state_q == StFetch && bus_io.mem_ack) begin
                operand_q <= bus_io.mem_rdata;
            end
            if (state_q == StExec) begin
                op1_q <= op1_exec;
                op2_q <= operand_q;
                if (wb_store) begin
                    result_q <= bus_io.alu_result[7:0];
                end
            end
        end
    end

    always_comb begin
        bus_io.issue_ready  = 1'b0;
        bus_io.rf_rd_sel    = src_q;
        bus_io.rf_wr_en     = 1'b0;
        bus_io.rf_wr_sel    = 3'd0;
        bus_io.rf_wr_data   = 8'h00;
        bus_io.f_wr_en      = 1'b0;
        bus_io.f_wr_data    = '0;
        bus_io.mem_req      = 1'b0;
        bus_io.mem_we       = 1'b0;
        bus_io.mem_addr_sel = 1'b0;
        bus_io.mem_wdata    = 8'h00;
        bus_io.alu_op1      = op1_q;
        bus_io.alu_op2      = op2_q;
        bus_io.alu_op_o     = OP_NOP;
        bus_io.alu_in_flags = '0;
        bus_io.done         = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus_io.issue_ready = 1'b1;
                // Steer the read port at the incoming source so the operand latches on accept.
                if (bus_io.issue_valid) bus_io.rf_rd_sel = bus_io.issue_src;
            end
            StFetch: begin
                bus_io.mem_req      = 1'b1;
                bus_io.mem_addr_sel = imm_q;
            end
            StExec: begin
                bus_io.alu_op_o     = op_q;
                bus_io.alu_in_flags = bus_io.rf_f;
                bus_io.alu_op1      = op1_exec;
                bus_io.alu_op2      = operand_q;
                if (op_q != OP_NOP) begin
                    bus_io.f_wr_en   = 1'b1;
                    bus_io.f_wr_data = bus_io.alu_out_flags;
                end
                if (op_q != OP_NOP && wb_q == 2'd1) begin
                    bus_io.rf_wr_en   = 1'b1;
                    bus_io.rf_wr_sel  = 3'd7;
                    bus_io.rf_wr_data = bus_io.alu_result[7:0];
                end else if (wb_reg) begin
                    bus_io.rf_wr_en   = 1'b1;
                    bus_io.rf_wr_sel  = src_q;
                    bus_io.rf_wr_data = bus_io.alu_result[7:0];
                end
                bus_io.done = !wb_store;
            end
            StStore: begin
                bus_io.mem_req   = 1'b1;
                bus_io.mem_we    = 1'b1;
                bus_io.mem_wdata = result_q;
                bus_io.done      = bus_io.mem_ack;
            end
            default: begin
                bus_io.issue_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small register-file, memory-handshake and ALU environment.
module tb_alu_issue;
    import sm83_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   acc_cnt;
    int   done_cnt;
    int   wr_cnt;
    int   acc_cyc[$];
    r8_t  regs [8];

    alu_issue_if iface ();

    alu_issue dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (iface)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        iface.rf_rd_data = regs[iface.rf_rd_sel];
        iface.rf_a       = regs[7];
    end

    // Reference ALU for the handful of ops exercised here.
    always_comb begin
        logic [8:0] sum;
        logic [4:0] hs;
        sum = 9'd0;
        hs  = 5'd0;
        iface.alu_result    = 8'h00;
        iface.alu_out_flags = '0;
        case (iface.alu_op_o)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, iface.alu_op1} + {1'b0, iface.alu_op2}
                    + ((iface.alu_op_o == OP_ADC) ? {8'd0, iface.alu_in_flags.c} : 9'd0);
                hs  = {1'b0, iface.alu_op1[3:0]} + {1'b0, iface.alu_op2[3:0]}
                    + ((iface.alu_op_o == OP_ADC) ? {4'd0, iface.alu_in_flags.c} : 5'd0);
                iface.alu_result      = sum[7:0];
                iface.alu_out_flags.z = (sum[7:0] == 8'h00);
                iface.alu_out_flags.h = hs[4];
                iface.alu_out_flags.c = sum[8];
            end
            OP_CP: begin
                iface.alu_result      = iface.alu_op1;
                iface.alu_out_flags.z = (iface.alu_op1 == iface.alu_op2);
                iface.alu_out_flags.n = 1'b1;
                iface.alu_out_flags.h = (iface.alu_op1[3:0] < iface.alu_op2[3:0]);
                iface.alu_out_flags.c = (iface.alu_op1 < iface.alu_op2);
            end
            OP_RLC: begin
                iface.alu_result      = {iface.alu_op2[6:0], iface.alu_op2[7]};
                iface.alu_out_flags.z = (iface.alu_op2 == 8'h00);
                iface.alu_out_flags.c = iface.alu_op2[7];
            end
            default: begin
                iface.alu_result = 8'h00;
            end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (iface.issue_valid && iface.issue_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc.push_back(cyc);
        end
        if (iface.done) done_cnt <= done_cnt + 1;
        if (iface.rf_wr_en) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_t op, input logic [2:0] src, input logic imm,
                         input logic [2:0] bitn, input logic [1:0] wb);
        iface.issue_op    = op;
        iface.issue_src   = src;
        iface.issue_imm   = imm;
        iface.issue_bit   = bitn;
        iface.issue_wb    = wb;
        iface.issue_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (iface.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", iface.issue_ready);
        end
        n_checks++;
        if (iface.alu_op_o !== OP_NOP) begin
            n_fail++; $display("FAIL reset_alu_op: got %0d want %0d", iface.alu_op_o, OP_NOP);
        end
        n_checks++;
        if ({iface.rf_wr_en, iface.f_wr_en, iface.mem_req, iface.mem_we, iface.mem_addr_sel,
             iface.done, iface.rf_rd_sel, iface.rf_wr_sel} !== 12'h000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {iface.rf_wr_en, iface.f_wr_en,
                iface.mem_req, iface.mem_we, iface.mem_addr_sel, iface.done});
        end
        n_checks++;
        if ({iface.alu_op1, iface.alu_op2, iface.rf_wr_data, iface.mem_wdata} !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", iface.alu_op1,
                iface.alu_op2, iface.rf_wr_data, iface.mem_wdata);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_adc_reg();
        regs[7] = 8'h3C;
        regs[0] = 8'h12;
        iface.rf_f = 4'b0001;
        issue(OP_ADC, 3'd0, 1'b0, 3'd0, 2'd1);
        #1;
        n_checks++;
        if (iface.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL adc_ready_T: got %b want 1", iface.issue_ready);
        end
        tick();
        iface.issue_valid = 1'b0;
        n_checks++;
        if ({iface.alu_op1, iface.alu_op2} !== 16'h3C12) begin
            n_fail++; $display("FAIL adc_operands: got %h want 3c12", {iface.alu_op1, iface.alu_op2});
        end
        n_checks++;
        if (iface.alu_op_o !== OP_ADC || iface.alu_in_flags !== 4'b0001) begin
            n_fail++; $display("FAIL adc_alu_ctl: got op %0d fl %b want %0d 0001",
                iface.alu_op_o, iface.alu_in_flags, OP_ADC);
        end
        n_checks++;
        if ({iface.rf_wr_en, iface.rf_wr_sel, iface.rf_wr_data} !== {1'b1, 3'd7, 8'h4F}) begin
            n_fail++; $display("FAIL adc_rf_wr: got %b/%0d/%h want 1/7/4f", iface.rf_wr_en,
                iface.rf_wr_sel, iface.rf_wr_data);
        end
        n_checks++;
        if ({iface.f_wr_en, iface.f_wr_data, iface.done, iface.issue_ready} !== 7'b1_0000_1_0) begin
            n_fail++; $display("FAIL adc_flags_done: got %b want 1000010",
                {iface.f_wr_en, iface.f_wr_data, iface.done, iface.issue_ready});
        end
        tick();
        n_checks++;
        if ({iface.issue_ready, iface.done, iface.rf_wr_en, iface.f_wr_en} !== 4'b1000) begin
            n_fail++; $display("FAIL adc_T2: got %b want 1000",
                {iface.issue_ready, iface.done, iface.rf_wr_en, iface.f_wr_en});
        end
        n_checks++;
        if (iface.alu_op_o !== OP_NOP || iface.alu_op1 !== 8'h3C || iface.alu_op2 !== 8'h12) begin
            n_fail++; $display("FAIL adc_hold: got op %0d %h %h want %0d 3c 12", iface.alu_op_o,
                iface.alu_op1, iface.alu_op2, OP_NOP);
        end
    endtask

    task automatic test_add_hl();
        regs[7] = 8'h01;
        iface.rf_f = 4'b0000;
        issue(OP_ADD, 3'd6, 1'b0, 3'd0, 2'd1);
        tick();
        iface.issue_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if ({iface.mem_req, iface.mem_we, iface.mem_addr_sel, iface.done} !== 4'b1000) begin
                n_fail++; $display("FAIL add_fetch_%0d: got %b want 1000", k,
                    {iface.mem_req, iface.mem_we, iface.mem_addr_sel, iface.done});
            end
            if (k == 3) begin
                iface.mem_ack   = 1'b1;
                iface.mem_rdata = 8'h0F;
            end
            tick();
            iface.mem_ack = 1'b0;
        end
        n_checks++;
        if ({iface.mem_req, iface.alu_op2} !== {1'b0, 8'h0F}) begin
            n_fail++; $display("FAIL add_exec_op2: got %b %h want 0 0f", iface.mem_req, iface.alu_op2);
        end
        n_checks++;
        if ({iface.rf_wr_en, iface.rf_wr_sel, iface.rf_wr_data} !== {1'b1, 3'd7, 8'h10}) begin
            n_fail++; $display("FAIL add_rf_wr: got %b/%0d/%h want 1/7/10", iface.rf_wr_en,
                iface.rf_wr_sel, iface.rf_wr_data);
        end
        n_checks++;
        if ({iface.f_wr_en, iface.f_wr_data, iface.done} !== 6'b1_0010_1) begin
            n_fail++; $display("FAIL add_flags: got %b want 100101",
                {iface.f_wr_en, iface.f_wr_data, iface.done});
        end
        tick();
    endtask

    task automatic test_rlc_hl_store();
        int wr_base;
        wr_base = wr_cnt;
        iface.rf_f = 4'b0000;
        issue(OP_RLC, 3'd6, 1'b0, 3'd0, 2'd2);
        tick();
        iface.issue_valid = 1'b0;
        n_checks++;
        if ({iface.mem_req, iface.mem_we, iface.mem_addr_sel} !== 3'b100) begin
            n_fail++; $display("FAIL rlc_fetch: got %b want 100",
                {iface.mem_req, iface.mem_we, iface.mem_addr_sel});
        end
        iface.mem_ack   = 1'b1;
        iface.mem_rdata = 8'h85;
        tick();
        iface.mem_ack = 1'b0;
        n_checks++;
        if ({iface.f_wr_en, iface.f_wr_data, iface.rf_wr_en, iface.done, iface.mem_req}
            !== 8'b1_0001_000) begin
            n_fail++; $display("FAIL rlc_exec: got %b want 10001000", {iface.f_wr_en,
                iface.f_wr_data, iface.rf_wr_en, iface.done, iface.mem_req});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({iface.mem_req, iface.mem_we, iface.mem_addr_sel, iface.mem_wdata, iface.done}
                !== {3'b110, 8'h0B, 1'b0}) begin
                n_fail++; $display("FAIL rlc_store_%0d: got %b %h %b want 110 0b 0", k,
                    {iface.mem_req, iface.mem_we, iface.mem_addr_sel}, iface.mem_wdata, iface.done);
            end
        end
        iface.mem_ack = 1'b1;
        #1;
        n_checks++;
        if (iface.done !== 1'b1) begin
            n_fail++; $display("FAIL rlc_done_on_ack: got %b want 1", iface.done);
        end
        tick();
        iface.mem_ack = 1'b0;
        n_checks++;
        if ({iface.mem_req, iface.issue_ready, iface.done} !== 3'b010) begin
            n_fail++; $display("FAIL rlc_idle: got %b want 010",
                {iface.mem_req, iface.issue_ready, iface.done});
        end
        n_checks++;
        if (wr_cnt !== wr_base) begin
            n_fail++; $display("FAIL rlc_no_rf_wr: got %0d writes want 0", wr_cnt - wr_base);
        end
    endtask

    task automatic test_cp_imm();
        regs[7] = 8'h42;
        iface.rf_f = 4'b0000;
        issue(OP_CP, 3'd3, 1'b1, 3'd0, 2'd2);
        tick();
        iface.issue_valid = 1'b0;
        n_checks++;
        if ({iface.mem_req, iface.mem_we, iface.mem_addr_sel} !== 3'b101) begin
            n_fail++; $display("FAIL cp_fetch: got %b want 101",
                {iface.mem_req, iface.mem_we, iface.mem_addr_sel});
        end
        iface.mem_ack   = 1'b1;
        iface.mem_rdata = 8'h42;
        tick();
        iface.mem_ack = 1'b0;
        n_checks++;
        if ({iface.f_wr_en, iface.f_wr_data, iface.rf_wr_en, iface.done, iface.mem_req}
            !== 8'b1_1100_010) begin
            n_fail++; $display("FAIL cp_exec: got %b want 11100010", {iface.f_wr_en,
                iface.f_wr_data, iface.rf_wr_en, iface.done, iface.mem_req});
        end
        n_checks++;
        if (iface.alu_op2 !== 8'h42 || iface.alu_op_o !== OP_CP) begin
            n_fail++; $display("FAIL cp_operand: got %h op %0d want 42 %0d", iface.alu_op2,
                iface.alu_op_o, OP_CP);
        end
        tick();
    endtask

    task automatic test_reset_in_fetch();
        int wr_base;
        int done_base;
        issue(OP_ADD, 3'd6, 1'b0, 3'd0, 2'd1);
        tick();
        iface.issue_valid = 1'b0;
        wr_base   = wr_cnt;
        done_base = done_cnt;
        n_checks++;
        if (iface.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstf_req_before: got %b want 1", iface.mem_req);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({iface.mem_req, iface.issue_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstf_async: got %b want 01", {iface.mem_req, iface.issue_ready});
        end
        tick();
        rst = 1'b0;
        iface.mem_ack   = 1'b1;
        iface.mem_rdata = 8'hFF;
        tick();
        iface.mem_ack = 1'b0;
        n_checks++;
        if ({iface.issue_ready, iface.mem_req, iface.rf_wr_en, iface.f_wr_en, iface.done}
            !== 5'b10000) begin
            n_fail++; $display("FAIL rstf_after: got %b want 10000", {iface.issue_ready,
                iface.mem_req, iface.rf_wr_en, iface.f_wr_en, iface.done});
        end
        tick();
        n_checks++;
        if (wr_cnt !== wr_base || done_cnt !== done_base) begin
            n_fail++; $display("FAIL rstf_no_writes: got wr %0d done %0d want 0 0",
                wr_cnt - wr_base, done_cnt - done_base);
        end
    endtask

    task automatic test_back_to_back();
        int acc_base;
        int done_base;
        int q_base;
        regs[1] = 8'h05;
        acc_base  = acc_cnt;
        done_base = done_cnt;
        q_base    = acc_cyc.size();
        issue(OP_ADD, 3'd1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_cnt - acc_base >= 3) break;
        end
        iface.issue_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (acc_cnt - acc_base !== 3) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - acc_base);
        end
        n_checks++;
        if (done_cnt - done_base !== 3) begin
            n_fail++; $display("FAIL b2b_dones: got %0d want 3", done_cnt - done_base);
        end
        n_checks++;
        if (acc_cyc.size() < q_base + 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d accepts want 3", acc_cyc.size() - q_base);
        end else if (acc_cyc[q_base+1] - acc_cyc[q_base] !== 2
                     || acc_cyc[q_base+2] - acc_cyc[q_base+1] !== 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d,%0d cycles want 2,2",
                acc_cyc[q_base+1] - acc_cyc[q_base], acc_cyc[q_base+2] - acc_cyc[q_base+1]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        iface.issue_valid = 1'b0;
        iface.issue_op    = OP_NOP;
        iface.issue_src   = 3'd0;
        iface.issue_imm   = 1'b0;
        iface.issue_bit   = 3'd0;
        iface.issue_wb    = 2'd0;
        iface.rf_f        = 4'b0000;
        iface.mem_ack     = 1'b0;
        iface.mem_rdata   = 8'h00;
        test_reset();
        test_adc_reg();
        test_add_hl();
        test_rlc_hl_store();
        test_cp_imm();
        test_reset_in_fetch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
